// File: rtl/morse_decoder.sv
// Morse receive stage: synchronizes the on/off line, times mark/space runs and
// decodes letters A..H into the transmitter's 3-bit code with valid/err pulses.
module morse_decoder #(
   parameter int UNIT_CYCLES = 25000000
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       morse_in,
   output logic [2:0] letter,
   output logic       letter_valid,
   output logic       letter_err,
   output logic [3:0] sym_bits,
   output logic [2:0] sym_count
);

   localparam int DASH_I = (2 * UNIT_CYCLES < 1) ? 1 : 2 * UNIT_CYCLES;
   localparam int GAP_I  = ((3 * UNIT_CYCLES) / 2 < 1) ? 1 : (3 * UNIT_CYCLES) / 2;
   localparam int MINM_I = (UNIT_CYCLES / 4 < 1) ? 1 : UNIT_CYCLES / 4;

   localparam logic [26:0] DASH_MIN = 27'(DASH_I);
   localparam logic [26:0] GAP_MIN  = 27'(GAP_I);
   localparam logic [26:0] MIN_MARK = 27'(MINM_I);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MARK,
      S_SPACE,
      S_EMIT
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_sync1;
   logic        r_sync2;
   logic [1:0]  r_primed;
   logic        r_armed;
   logic [26:0] r_cnt;
   logic [26:0] w_cnt_nxt;
   logic [3:0]  r_bits;
   logic [3:0]  w_bits_nxt;
   logic [2:0]  r_count;
   logic [2:0]  w_count_nxt;
   logic        r_bad;
   logic        w_bad_nxt;
   logic [2:0]  r_letter;
   logic [2:0]  w_letter_nxt;
   logic        r_valid;
   logic        w_valid_nxt;
   logic        r_err;
   logic        w_err_nxt;
   logic        w_s;
   logic        w_short;
   logic        w_dash;
   logic [3:0]  w_dec;

   // Returns {hit, code}; symbols sit first-in-MSB within the low sym_count bits.
   function automatic logic [3:0] decode(input logic [2:0] cnt, input logic [3:0] bits);
      logic [3:0] res;
      res = 4'b0000;
      case ({cnt, bits})
         7'b010_0001: res = {1'b1, 3'd0};
         7'b100_1000: res = {1'b1, 3'd1};
         7'b100_1010: res = {1'b1, 3'd2};
         7'b011_0100: res = {1'b1, 3'd3};
         7'b001_0000: res = {1'b1, 3'd4};
         7'b100_0010: res = {1'b1, 3'd5};
         7'b011_0110: res = {1'b1, 3'd6};
         7'b100_0000: res = {1'b1, 3'd7};
         default:     res = 4'b0000;
      endcase
      return res;
   endfunction

   assign w_s     = r_sync2;
   assign w_short = (r_cnt < MIN_MARK);
   assign w_dash  = !w_short && (r_cnt >= DASH_MIN);
   assign w_dec   = decode(r_count, r_bits);

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_bits_nxt   = r_bits;
      w_count_nxt  = r_count;
      w_bad_nxt    = r_bad;
      w_letter_nxt = r_letter;
      w_valid_nxt  = 1'b0;
      w_err_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // r_armed guarantees a genuine low was seen, so a line held high
            // through reset release cannot start a letter.
            if (w_s && r_armed) begin
               w_state_nxt = S_MARK;
               w_cnt_nxt   = 27'd1;
               w_bits_nxt  = 4'd0;
               w_count_nxt = 3'd0;
               w_bad_nxt   = 1'b0;
            end
         end
         S_MARK: begin
            if (w_s) begin
               if (r_cnt < DASH_MIN) w_cnt_nxt = r_cnt + 27'd1;
            end else begin
               if (w_short) w_bad_nxt = 1'b1;
               if (r_count >= 3'd4) begin
                  w_bad_nxt   = 1'b1;
                  w_count_nxt = 3'd5;
               end else begin
                  w_bits_nxt  = {r_bits[2:0], w_dash};
                  w_count_nxt = r_count + 3'd1;
               end
               w_state_nxt = S_SPACE;
               w_cnt_nxt   = 27'd1;
            end
         end
         S_SPACE: begin
            // The gap test wins over a coinciding rise so a space of exactly
            // GAP_MIN always ends the letter.
            if (r_cnt == GAP_MIN) begin
               w_state_nxt = S_EMIT;
               if (!r_bad && w_dec[3]) begin
                  w_valid_nxt  = 1'b1;
                  w_letter_nxt = w_dec[2:0];
               end else begin
                  w_err_nxt = 1'b1;
               end
            end else if (w_s) begin
               w_state_nxt = S_MARK;
               w_cnt_nxt   = 27'd1;
            end else begin
               w_cnt_nxt = r_cnt + 27'd1;
            end
         end
         S_EMIT: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!Resetn) begin
         r_state  <= S_IDLE;
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_primed <= 2'b00;
         r_armed  <= 1'b0;
         r_cnt    <= 27'd0;
         r_bits   <= 4'd0;
         r_count  <= 3'd0;
         r_bad    <= 1'b0;
         r_letter <= 3'd0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sync1  <= morse_in;
         r_sync2  <= r_sync1;
         // Cleared sync flops read as low for two cycles after reset; ignore them.
         r_primed <= {r_primed[0], 1'b1};
         if (r_primed[1] && !r_sync2) r_armed <= 1'b1;
         r_cnt    <= w_cnt_nxt;
         r_bits   <= w_bits_nxt;
         r_count  <= w_count_nxt;
         r_bad    <= w_bad_nxt;
         r_letter <= w_letter_nxt;
         r_valid  <= w_valid_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign letter       = r_letter;
   assign letter_valid = r_valid;
   assign letter_err   = r_err;
   assign sym_bits     = r_bits;
   assign sym_count    = r_count;

endmodule
